multi_gate_checker: RTL and testbench

Parametrised tester for quad/hex logic-gate ICs. It exhaustively drives every input pattern onto all gate channels of the device under test (DUT) and holds each pattern for a settle interval. It then compares each channel's output against an internal reference gate of the selected type and reports per-channel and overall pass/fail. It sits between the board-level IC socket pins and the result LEDs/UI, and replaces the fixed single-type checkers.

---
 rtl/ic_tester_pkg.sv | 26 ++
 rtl/gate_ref_model.sv | 27 ++
 rtl/multi_gate_checker.sv | 156 +++++++++++++++
 tb/tb_multi_gate_checker.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_tester_pkg.sv
// Shared definitions for the logic-gate IC checkers: gate selector
// encodings, the checker state machine states and the default settle time.
package ic_tester_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_NOT  = 3'd6,
    GATE_RSVD = 3'd7
  } gate_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  // Clocks each pattern is held on the socket before the outputs are sampled.
  localparam int unsigned SETTLE_DEFAULT = 12_500_000;

endpackage

// File: rtl/gate_ref_model.sv
// Reference gate: the bit a healthy gate of the selected type must produce
// for the given input pattern.
module gate_ref_model
  import ic_tester_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] pattern,
  input  gate_sel_t       gate_sel,
  output logic            expected
);

  // Reduction of the pattern with optional inversion; NOT only looks at bit 0.
  always_comb begin
    case (gate_sel)
      GATE_AND:  expected = &pattern;
      GATE_OR:   expected = |pattern;
      GATE_NAND: expected = ~&pattern;
      GATE_NOR:  expected = ~|pattern;
      GATE_XOR:  expected = ^pattern;
      GATE_XNOR: expected = ~^pattern;
      GATE_NOT:  expected = ~pattern[0];
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_gate_checker.sv
// Exhaustive tester for quad/hex gate ICs: walks every input pattern onto all
// channels, lets each settle, compares each channel against the reference
// gate and publishes sticky per-channel and overall pass/fail results.
module multi_gate_checker
  import ic_tester_pkg::*;
#(
  parameter int          CHANNELS      = 4,
  parameter int          N_IN          = 2,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     enable,
  input  logic [2:0]               gate_sel,
  output logic [CHANNELS*N_IN-1:0] A,
  input  logic [CHANNELS-1:0]      op,
  output logic [CHANNELS-1:0]      pass_ch,
  output logic [CHANNELS-1:0]      fail_ch,
  output logic                     pass,
  output logic                     fail,
  output logic                     busy,
  output logic                     done
);

  localparam int            CW         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t                state;
  gate_sel_t             gate_q;
  logic [N_IN-1:0]       pattern;
  logic [CW-1:0]         count;
  logic [CHANNELS-1:0]   mismatch;

  logic [N_IN-1:0]       pat_mask;
  logic [N_IN-1:0]       pat_eff;
  logic                  expected;
  logic [CHANNELS-1:0]   miss_now;

  // Pattern as seen by the socket (NOT mode uses bit 0 only) and the
  // per-channel comparison against the reference bit.
  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    pat_mask = (gate_q == GATE_NOT) ? N_IN'(1) : {N_IN{1'b1}};
    pat_eff  = pattern & pat_mask;
    miss_now = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // Case inequality so an X/Z on a socket pin registers as a mismatch.
      miss_now[c] = (op[c] !== expected);
    end
  end

  gate_ref_model #(
    .N_IN(N_IN)
  ) u_ref (
    .pattern (pat_eff),
    .gate_sel(gate_q),
    .expected(expected)
  );

  // Test sequencer: settle counter, pattern walk, sticky mismatch and result registers.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gate_q   <= GATE_AND;
      pattern  <= '0;
      count    <= '0;
      mismatch <= '0;
      A        <= '0;
      pass_ch  <= '0;
      fail_ch  <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && enable) begin
            gate_q   <= gate_sel_t'(gate_sel);
            pattern  <= '0;
            count    <= '0;
            mismatch <= '0;
            pass_ch  <= '0;
            fail_ch  <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_DRIVE;
          end else if (!enable) begin
            pass_ch <= '0;
            fail_ch <= '0;
            pass    <= 1'b0;
            fail    <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (!enable) begin
            A       <= '0;
            busy    <= 1'b0;
            pattern <= '0;
            count   <= '0;
            state   <= ST_IDLE;
          end else if (gate_q == GATE_RSVD) begin
            // Unknown gate type: fail every channel without touching the socket.
            mismatch <= '1;
            state    <= ST_FINISH;
          end else begin
            A <= {CHANNELS{pat_eff}};
            if (count == COUNT_LAST) begin
              state <= ST_SAMPLE;
            end else begin
              count <= count + CW'(1);
            end
          end
        end

        ST_SAMPLE: begin
          if (!enable) begin
            A       <= '0;
            busy    <= 1'b0;
            pattern <= '0;
            count   <= '0;
            state   <= ST_IDLE;
          end else begin
            mismatch <= mismatch | miss_now;
            if (pattern == pat_mask) begin
              state <= ST_FINISH;
            end else begin
              pattern <= pattern + N_IN'(1);
              count   <= '0;
              state   <= ST_DRIVE;
            end
          end
        end

        ST_FINISH: begin
          fail_ch <= mismatch;
          pass_ch <= ~mismatch;
          pass    <= ~|mismatch;
          fail    <= |mismatch;
          done    <= 1'b1;
          busy    <= 1'b0;
          A       <= '0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_gate_checker.sv
// Scoreboard bench for multi_gate_checker: three configurations, behavioural
// gate ICs with injectable faults, expected results queued at each start and
// checked by per-instance monitors whenever done pulses.
`timescale 1ns/1ps
module tb_multi_gate_checker;
  import ic_tester_pkg::*;

  localparam int S = 4;

  typedef struct {
    logic [7:0] pass_ch;
    logic [7:0] fail_ch;
    logic       pass;
    logic       fail;
    int         lat;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic [2:0] ic_sel = 3'd0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic [7:0]  A_a;  logic [3:0] op_a, pass_ch_a, fail_ch_a;  logic pass_a, fail_a, busy_a, done_a;
  logic [11:0] A_b;  logic [5:0] op_b, pass_ch_b, fail_ch_b;  logic pass_b, fail_b, busy_b, done_b;
  logic [11:0] A_c;  logic [3:0] op_c, pass_ch_c, fail_ch_c;  logic pass_c, fail_c, busy_c, done_c;

  logic [3:0] stuck0_a = 4'd0;
  logic [3:0] flip_c = 4'd0;
  logic [2:0] flip_pat_c = 3'd0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  exp_t       q_a[$], q_b[$], q_c[$];
  logic [7:0] hist_a[$];
  bit         b_upper_seen = 1'b0;
  bit         b_toggle_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  multi_gate_checker #(.CHANNELS(4), .N_IN(2), .SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .enable(enable), .gate_sel(gate_sel),
    .A(A_a), .op(op_a), .pass_ch(pass_ch_a), .fail_ch(fail_ch_a),
    .pass(pass_a), .fail(fail_a), .busy(busy_a), .done(done_a));

  multi_gate_checker #(.CHANNELS(6), .N_IN(2), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .enable(enable), .gate_sel(gate_sel),
    .A(A_b), .op(op_b), .pass_ch(pass_ch_b), .fail_ch(fail_ch_b),
    .pass(pass_b), .fail(fail_b), .busy(busy_b), .done(done_b));

  multi_gate_checker #(.CHANNELS(4), .N_IN(3), .SETTLE_CYCLES(S)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .enable(enable), .gate_sel(gate_sel),
    .A(A_c), .op(op_c), .pass_ch(pass_ch_c), .fail_ch(fail_ch_c),
    .pass(pass_c), .fail(fail_c), .busy(busy_c), .done(done_c));

  // Behaviour of one gate of the IC sitting in the socket.
  function automatic logic gate_fn(input logic [2:0] sel, input logic [3:0] bits, input int n);
    logic r_and, r_or, r_xor;
    r_and = 1'b1; r_or = 1'b0; r_xor = 1'b0;
    for (int i = 0; i < n; i++) begin
      r_and &= bits[i]; r_or |= bits[i]; r_xor ^= bits[i];
    end
    case (sel)
      3'd0: return r_and;
      3'd1: return r_or;
      3'd2: return ~r_and;
      3'd3: return ~r_or;
      3'd4: return r_xor;
      3'd5: return ~r_xor;
      3'd6: return ~bits[0];
      default: return 1'b0;
    endcase
  endfunction

  // Socketed ICs, with a stuck-at-0 fault on instance a and a pattern-specific inversion on c.
  always_comb begin
    op_a = '0;
    for (int c = 0; c < 4; c++) begin
      op_a[c] = gate_fn(ic_sel, {2'b00, A_a[c*2 +: 2]}, 2);
      if (stuck0_a[c]) op_a[c] = 1'b0;
    end
  end

  always_comb begin
    op_b = '0;
    for (int c = 0; c < 6; c++) op_b[c] = gate_fn(ic_sel, {2'b00, A_b[c*2 +: 2]}, 2);
  end

  always_comb begin
    op_c = '0;
    for (int c = 0; c < 4; c++) begin
      op_c[c] = gate_fn(ic_sel, {1'b0, A_c[c*3 +: 3]}, 3);
      if (flip_c[c] && (A_c[c*3 +: 3] == flip_pat_c)) op_c[c] = ~op_c[c];
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] pch, input logic [7:0] fch,
                                  input logic p, input logic f, input int lat, input int t0);
    exp_t e;
    e.pass_ch = pch; e.fail_ch = fch; e.pass = p; e.fail = f; e.lat = lat; e.t0 = t0;
    return e;
  endfunction

  task automatic compare_result(input string tag, input logic [7:0] pch, input logic [7:0] fch,
                                input logic p, input logic f, input exp_t e);
    check({tag, "_pass_ch"}, pch, e.pass_ch);
    check({tag, "_fail_ch"}, fch, e.fail_ch);
    check({tag, "_pass"}, p, e.pass);
    check({tag, "_fail"}, f, e.fail);
    check({tag, "_latency"}, 32'(cycle - e.t0), 32'(e.lat));
  endtask

  // Monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_done", done_a, 32'd0);
      else begin e = q_a.pop_front(); compare_result("a", {4'b0, pass_ch_a}, {4'b0, fail_ch_a}, pass_a, fail_a, e); end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_done", done_b, 32'd0);
      else begin e = q_b.pop_front(); compare_result("b", {2'b0, pass_ch_b}, {2'b0, fail_ch_b}, pass_b, fail_b, e); end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (done_c === 1'b1) begin
      if (q_c.size() == 0) check("c_unexpected_done", done_c, 32'd0);
      else begin e = q_c.pop_front(); compare_result("c", {4'b0, pass_ch_c}, {4'b0, fail_ch_c}, pass_c, fail_c, e); end
    end
  end

  // Record the socket drive: distinct values of A_a while busy, and bit usage on instance b.
  always @(negedge clk) begin
    if (busy_a === 1'b1 && (hist_a.size() == 0 || hist_a[$] != A_a)) hist_a.push_back(A_a);
    if (busy_b === 1'b1) begin
      if ((A_b & 12'hAAA) != 12'h000) b_upper_seen = 1'b1;
      if (A_b == 12'h555) b_toggle_seen = 1'b1;
    end
  end

  task automatic do_start(input int idx, output int t0);
    @(negedge clk);
    case (idx)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    t0 = cycle;
  endtask

  task automatic wait_done(input int idx, input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      case (idx)
        0: seen = (done_a === 1'b1);
        1: seen = (done_b === 1'b1);
        default: seen = (done_c === 1'b1);
      endcase
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_a_value(input logic [7:0] v, input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = (A_a == v);
    end
    check(name, A_a, v);
  endtask

  initial begin
    int t0;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", {A_a, pass_ch_a, fail_ch_a, pass_a, fail_a, busy_a, done_a}, 32'd0);
    check("rst_b", {A_b, pass_ch_b, fail_ch_b, pass_b, fail_b, busy_b, done_b}, 32'd0);
    check("rst_c", {A_c, pass_ch_c, fail_ch_c, pass_c, fail_c, busy_c, done_c}, 32'd0);
    @(negedge clk);
    reset = 1'b0; enable = 1'b1;

    // NAND, ideal IC, with a second start mid-test that must be ignored.
    hist_a.delete();
    gate_sel = GATE_NAND; ic_sel = GATE_NAND; stuck0_a = 4'b0000;
    do_start(0, t0);
    q_a.push_back(mk_exp(8'h0F, 8'h00, 1'b1, 1'b0, 21, t0));
    check("t1_busy", busy_a, 32'd1);
    repeat (6) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 40, "t1");
    check("t1_pattern_count", 32'(hist_a.size()), 32'd4);
    if (hist_a.size() == 4) begin
      check("t1_pat0", hist_a[0], 8'h00);
      check("t1_pat1", hist_a[1], 8'h55);
      check("t1_pat2", hist_a[2], 8'hAA);
      check("t1_pat3", hist_a[3], 8'hFF);
    end
    repeat (2) @(negedge clk);
    check("t1_held_pass", pass_a, 32'd1);
    check("t1_held_pass_ch", pass_ch_a, 32'hF);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("idle_disable_clears", {pass_ch_a, fail_ch_a, pass_a, fail_a}, 32'd0);
    @(negedge clk);
    enable = 1'b1;

    // XOR with channel 2 stuck at 0.
    gate_sel = GATE_XOR; ic_sel = GATE_XOR; stuck0_a = 4'b0100;
    do_start(0, t0);
    q_a.push_back(mk_exp(8'h0B, 8'h04, 1'b0, 1'b1, 21, t0));
    wait_done(0, 40, "t2");
    stuck0_a = 4'b0000;
    repeat (2) @(negedge clk);
    check("t2_held_fail", fail_a, 32'd1);

    // Abort by dropping enable during the third pattern.
    gate_sel = GATE_AND; ic_sel = GATE_AND;
    do_start(0, t0);
    check("abort_results_cleared_on_start", {pass_ch_a, fail_ch_a, pass_a, fail_a}, 32'd0);
    wait_a_value(8'hAA, 40, "abort_third_pattern");
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy_a, 32'd0);
    check("abort_A", A_a, 32'd0);
    check("abort_outputs", {pass_ch_a, fail_ch_a, pass_a, fail_a, done_a}, 32'd0);
    @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);

    // Asynchronous reset in the middle of DRIVE.
    do_start(0, t0);
    wait_a_value(8'h55, 40, "reset_pattern_reached");
    check("reset_busy_before", busy_a, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_busy", busy_a, 32'd0);
    check("async_reset_A", A_a, 32'd0);
    check("async_reset_outputs", {pass_ch_a, fail_ch_a, pass_a, fail_a, done_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // NOT mode on six channels.
    gate_sel = GATE_NOT; ic_sel = GATE_NOT;
    b_upper_seen = 1'b0; b_toggle_seen = 1'b0;
    do_start(1, t0);
    q_b.push_back(mk_exp(8'h3F, 8'h00, 1'b1, 1'b0, 11, t0));
    wait_done(1, 30, "t3");
    check("t3_upper_bits_zero", 32'(b_upper_seen), 32'd0);
    check("t3_bit0_toggled", 32'(b_toggle_seen), 32'd1);

    // Reserved selector: immediate all-channel fail, socket untouched.
    gate_sel = 3'd7; ic_sel = GATE_AND;
    hist_a.delete();
    do_start(0, t0);
    q_a.push_back(mk_exp(8'h00, 8'h0F, 1'b0, 1'b1, 2, t0));
    wait_done(0, 10, "t4");
    check("t4_A_history_len", 32'(hist_a.size()), 32'd1);
    check("t4_A_zero", (hist_a.size() > 0) ? hist_a[0] : 8'hEE, 32'd0);

    // AND on three inputs: channel 0 wrong only on the last pattern 111.
    gate_sel = GATE_AND; ic_sel = GATE_AND;
    flip_c = 4'b0001; flip_pat_c = 3'b111;
    do_start(2, t0);
    q_c.push_back(mk_exp(8'h0E, 8'h01, 1'b0, 1'b1, 41, t0));
    wait_done(2, 60, "t6a");

    // Channel 3 wrong only on the first pattern: the flag must survive seven more samples.
    flip_c = 4'b1000; flip_pat_c = 3'b000;
    do_start(2, t0);
    q_c.push_back(mk_exp(8'h07, 8'h08, 1'b0, 1'b1, 41, t0));
    wait_done(2, 60, "t6b");
    flip_c = 4'b0000;

    repeat (3) @(negedge clk);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    check("q_c_drained", 32'(q_c.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
